// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit FSM states, common scan codes
// and the parity helper used when a command byte is latched.
package ps2_pkg;

    typedef enum logic [3:0] {
        IDLE,
        INHIBIT,
        REQ,
        DATA,
        PARITY,
        STOP,
        ACK,
        WAIT_IDLE,
        DONE,
        ERR
    } ps2_state_e;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] SC_CAPS      = 8'h58;
    localparam logic [7:0] SC_LSHIFT    = 8'h12;
    localparam logic [7:0] SC_RSHIFT    = 8'h59;
    localparam logic [7:0] SC_ENTER     = 8'h5A;
    localparam logic [7:0] SC_BKSP      = 8'h66;
    localparam logic [7:0] RSP_ACK      = 8'hFA;

    // Odd parity: the parity bit makes the total count of ones in the frame odd.
    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for one raw PS/2 line plus falling-edge detect
// on the synchronized value.
module ps2_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_sync,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // NOTE: reset to 1 (idle bus level) so leaving reset never looks like a falling edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_prev <= 1'b1;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_sync = r_sync;
    assign o_fall = r_prev & ~r_sync;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues a request-to-send,
// shifts a command byte out on device clock edges and checks the device ACK.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] txData,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES - 1);

    logic w_clk_sync;
    logic w_clk_fall;
    logic w_data_sync;
    logic w_data_fall_unused;

    ps2_sync_edge u_clk_sync (
        .clk    (clk),
        .rst    (rst),
        .i_async(ps2_clk_in),
        .o_sync (w_clk_sync),
        .o_fall (w_clk_fall)
    );

    ps2_sync_edge u_data_sync (
        .clk    (clk),
        .rst    (rst),
        .i_async(ps2_data_in),
        .o_sync (w_data_sync),
        .o_fall (w_data_fall_unused)
    );

    ps2_state_e       r_state;
    logic [7:0]       r_data;
    logic             r_parity;
    logic [2:0]       r_bit_cnt;
    logic [INH_W-1:0] r_inh_cnt;
    logic [TMO_W-1:0] r_timer;
    logic             r_clk_oe;
    logic             r_data_oe;
    logic             r_busy;
    logic             r_done;
    logic             r_error;

    logic w_timed;
    assign w_timed = (r_state inside {DATA, PARITY, STOP, ACK, WAIT_IDLE});

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_data    <= '0;
            r_parity  <= 1'b0;
            r_bit_cnt <= '0;
            r_inh_cnt <= '0;
            r_timer   <= '0;
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_error <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_data    <= txData;
                        r_parity  <= odd_parity(txData);
                        r_bit_cnt <= '0;
                        r_inh_cnt <= '0;
                        r_clk_oe  <= 1'b1;
                        r_busy    <= 1'b1;
                        r_state   <= INHIBIT;
                    end
                end
                INHIBIT: begin
                    if (r_inh_cnt == INH_LAST) begin
                        r_data_oe <= 1'b1;
                        r_timer   <= TMO_LOAD;
                        r_state   <= REQ;
                    end else begin
                        r_inh_cnt <= r_inh_cnt + 1'b1;
                    end
                end
                REQ: begin
                    r_clk_oe <= 1'b0;
                    r_state  <= DATA;
                end
                DATA: begin
                    if (w_clk_fall) begin
                        r_data_oe <= ~r_data[r_bit_cnt];
                        if (r_bit_cnt == 3'd7) begin
                            r_state <= PARITY;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                end
                PARITY: begin
                    if (w_clk_fall) begin
                        r_data_oe <= ~r_parity;
                        r_state   <= STOP;
                    end
                end
                STOP: begin
                    if (w_clk_fall) begin
                        r_data_oe <= 1'b0;
                        r_state   <= ACK;
                    end
                end
                ACK: begin
                    if (w_clk_fall) begin
                        r_state <= w_data_sync ? ERR : WAIT_IDLE;
                        r_error <= w_data_sync;
                    end
                end
                WAIT_IDLE: begin
                    if (w_clk_sync && w_data_sync) begin
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE, ERR: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_clk_oe  <= 1'b0;
                    r_data_oe <= 1'b0;
                    r_busy    <= 1'b0;
                    r_state   <= IDLE;
                end
            endcase

            // Watchdog between device clock edges; expiry overrides the state action above.
            if (w_timed) begin
                if (w_clk_fall) begin
                    r_timer <= TMO_LOAD;
                end else if (r_timer == '0) begin
                    r_clk_oe  <= 1'b0;
                    r_data_oe <= 1'b0;
                    r_done    <= 1'b0;
                    r_error   <= 1'b1;
                    r_state   <= ERR;
                end else begin
                    r_timer <= r_timer - 1'b1;
                end
            end
        end
    end

    assign ps2_clk_oe  = r_clk_oe;
    assign ps2_data_oe = r_data_oe;
    assign busy        = r_busy;
    assign done        = r_done;
    assign error       = r_error;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: a table of command bytes sent through a
// behavioural keyboard model, plus timeout, busy-start and reset sequences.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int HALF = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [7:0] txData = 8'h00;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;
    logic       ps2_clk_in;
    logic       ps2_data_in;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       busy;
    logic       done;
    logic       error;

    ps2_host_tx #(
        .INHIBIT_CYCLES(10),
        .TIMEOUT_CYCLES(200)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .txData     (txData),
        .ps2_clk_in (ps2_clk_in),
        .ps2_data_in(ps2_data_in),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    // Open-drain bus: either side pulling low wins.
    assign ps2_clk_in  = dev_clk  & ~ps2_clk_oe;
    assign ps2_data_in = dev_data & ~ps2_data_oe;

    int n_checks = 0;
    int n_pass   = 0;
    int n_done   = 0;
    int n_err    = 0;
    int n_both   = 0;

    always @(negedge clk) begin
        if (done)          n_done <= n_done + 1;
        if (error)         n_err  <= n_err + 1;
        if (done && error) n_both <= n_both + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic host_request(input logic [7:0] b, output int inh, output int req);
        @(negedge clk);
        txData = b;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        txData = 8'h00;
        inh = 0;
        while (ps2_clk_oe && !ps2_data_oe && inh < 100) begin
            inh++;
            @(negedge clk);
        end
        req = 0;
        while (ps2_clk_oe && ps2_data_oe && req < 100) begin
            req++;
            @(negedge clk);
        end
    endtask

    task automatic clock_edges(input int n, input logic ack_bit, input logic dup,
                               output logic [10:0] line);
        line = '1;
        for (int k = 0; k < n; k++) begin
            if (k == 10) dev_data = ack_bit;
            repeat (HALF) @(negedge clk);
            dev_clk = 1'b0;
            if (dup && k == 3) begin
                check("busy_during_dup_start", 32'(busy), 32'd1);
                start  = 1'b1;
                txData = 8'hA5;
                @(negedge clk);
                start  = 1'b0;
                txData = 8'h00;
            end
            repeat (HALF) @(negedge clk);
            line[k] = ps2_data_in;
            dev_clk = 1'b1;
        end
        dev_data = 1'b1;
    endtask

    task automatic wait_not_busy();
        int n;
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    typedef struct {
        logic [7:0] tx;
        logic       ack;
        logic       dup;
        logic       exp_par;
        int         exp_done;
        int         exp_err;
    } vec_t;

    vec_t vecs[10];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got running, expected finished");
        $fatal(1);
    end

    initial begin
        int         inh;
        int         req;
        int         d0;
        int         e0;
        int         n;
        logic [10:0] line;

        vecs[0] = '{CMD_SET_LEDS, 1'b0, 1'b0, 1'b1, 1, 0};
        vecs[1] = '{8'h00,        1'b0, 1'b0, 1'b1, 1, 0};
        vecs[2] = '{8'hFF,        1'b0, 1'b0, 1'b1, 1, 0};
        vecs[3] = '{8'h01,        1'b0, 1'b0, 1'b0, 1, 0};
        vecs[4] = '{SC_CAPS,      1'b1, 1'b0, 1'b0, 0, 1};
        vecs[5] = '{SC_LSHIFT,    1'b0, 1'b1, 1'b1, 1, 0};
        vecs[6] = '{SC_RSHIFT,    1'b0, 1'b0, 1'b1, 1, 0};
        vecs[7] = '{SC_ENTER,     1'b0, 1'b0, 1'b1, 1, 0};
        vecs[8] = '{SC_BKSP,      1'b1, 1'b0, 1'b1, 0, 1};
        vecs[9] = '{RSP_ACK,      1'b0, 1'b0, 1'b1, 1, 0};

        repeat (3) @(negedge clk);
        check("reset_clk_oe",  32'(ps2_clk_oe),  32'd0);
        check("reset_data_oe", 32'(ps2_data_oe), 32'd0);
        check("reset_busy",    32'(busy),        32'd0);
        check("reset_done",    32'(done),        32'd0);
        check("reset_error",   32'(error),       32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            d0 = n_done;
            e0 = n_err;
            host_request(vecs[i].tx, inh, req);
            check($sformatf("v%0d_inhibit_cycles", i), 32'(inh), 32'd10);
            check($sformatf("v%0d_req_cycles", i), 32'(req), 32'd1);
            check($sformatf("v%0d_clk_released", i), 32'(ps2_clk_oe), 32'd0);
            check($sformatf("v%0d_start_bit", i), 32'(ps2_data_in), 32'd0);
            clock_edges(11, vecs[i].ack, vecs[i].dup, line);
            wait_not_busy();
            check($sformatf("v%0d_data_bits", i), 32'(line[7:0]), 32'(vecs[i].tx));
            check($sformatf("v%0d_parity", i), 32'(line[8]), 32'(vecs[i].exp_par));
            check($sformatf("v%0d_stop", i), 32'(line[9]), 32'd1);
            check($sformatf("v%0d_done_pulses", i), 32'(n_done - d0), 32'(vecs[i].exp_done));
            check($sformatf("v%0d_error_pulses", i), 32'(n_err - e0), 32'(vecs[i].exp_err));
            check($sformatf("v%0d_oe_idle", i), 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
            check($sformatf("v%0d_busy_idle", i), 32'(busy), 32'd0);
        end

        // Device never clocks: error must appear 200 cycles after clock release.
        d0 = n_done;
        e0 = n_err;
        host_request(SC_ENTER, inh, req);
        n = 0;
        while (!error && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("timeout_latency", 32'(n), 32'd200);
        check("timeout_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
        wait_not_busy();
        repeat (2) @(negedge clk);
        check("timeout_error_pulses", 32'(n_err - e0), 32'd1);
        check("timeout_done_pulses", 32'(n_done - d0), 32'd0);

        // Reset in the middle of the data bits.
        host_request(CMD_SET_LEDS, inh, req);
        clock_edges(3, 1'b0, 1'b0, line);
        @(negedge clk);
        check("pre_reset_busy", 32'(busy), 32'd1);
        d0 = n_done;
        e0 = n_err;
        rst = 1'b0;
        #1;
        check("mid_reset_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
        check("mid_reset_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        clock_edges(8, 1'b0, 1'b0, line);
        repeat (30) @(negedge clk);
        check("post_reset_done", 32'(n_done - d0), 32'd0);
        check("post_reset_error", 32'(n_err - e0), 32'd0);
        check("post_reset_busy", 32'(busy), 32'd0);
        check("done_error_overlap", 32'(n_both), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
